// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, 50 MHz defaults and width helper for the key debouncer
package key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } key_state_t;

   localparam int DEB_CYCLES_50M    = 1_000_000;   // 20 ms
   localparam int HOLD_CYCLES_50M   = 25_000_000;  // 500 ms
   localparam int REPEAT_CYCLES_50M = 5_000_000;   // 100 ms

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_sync_filter.sv
// rtl/key_sync_filter.sv - 2-flop synchronizer and consecutive-sample debounce filter
module key_sync_filter
   import key_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_50M
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic level_o,
   output logic changed_o
);

   localparam int             DW       = cnt_width(DEB_CYCLES);
   localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          changed_q, changed_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          sample_pressed;

   assign sample_pressed = ~sync2_q;

   // Any matching sample restarts the count, so short glitches leave no trace.
   always_comb begin
      stable_d  = stable_q;
      changed_d = 1'b0;
      cnt_d     = '0;
      if (sample_pressed != stable_q) begin
         if (cnt_q == DEB_LAST) begin
            stable_d  = ~stable_q;
            changed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b0;
         changed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= key_n_i;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level_o   = stable_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounced push-button with press/release pulses and hold-to-repeat
module key_debounce
   import key_pkg::*;
#(
   parameter int DEB_CYCLES    = DEB_CYCLES_50M,
   parameter int HOLD_CYCLES   = HOLD_CYCLES_50M,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_50M
) (
   input  logic CLOCK_50,
   input  logic RESET,
   input  logic KEY_N,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int            HR_MAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int            CW          = cnt_width(HR_MAX);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

   logic          stable_level;
   logic          stable_changed;
   key_state_t    state_q;
   logic [CW-1:0] cnt_q;
   logic          level_q, press_q, release_q, repeat_q;

   key_sync_filter #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_filter (
      .clk_i     (CLOCK_50),
      .rst_i     (RESET),
      .key_n_i   (KEY_N),
      .level_o   (stable_level),
      .changed_o (stable_changed)
   );

   // Release is tested before the terminal count so it wins a same-cycle collision.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (stable_changed && stable_level) begin
                  state_q <= ST_HOLD;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (stable_changed && !stable_level) begin
                  state_q   <= ST_IDLE;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  cnt_q     <= '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_q  <= ST_REPEAT;
                  repeat_q <= 1'b1;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_REPEAT: begin
               if (stable_changed && !stable_level) begin
                  state_q   <= ST_IDLE;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  cnt_q     <= '0;
               end else if (cnt_q == REPEAT_LAST) begin
                  repeat_q <= 1'b1;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               level_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed, table-driven bench for key_debounce
module tb_key_debounce;
   import key_pkg::*;

   localparam int DEB    = 4;
   localparam int HOLD   = 20;
   localparam int REP    = 8;
   localparam int NVEC_A = 90;

   logic clk = 1'b0;
   logic rst;
   logic key_n;
   logic level, press, rel, rep;

   always #5 clk = ~clk;

   key_debounce #(
      .DEB_CYCLES    (DEB),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .CLOCK_50      (clk),
      .RESET         (rst),
      .KEY_N         (key_n),
      .key_level     (level),
      .press_pulse   (press),
      .release_pulse (rel),
      .repeat_pulse  (rep)
   );

   // exp packs {key_level, press_pulse, release_pulse, repeat_pulse}
   typedef struct {
      logic       rst;
      logic       key_n;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs [NVEC_A];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n;

   task automatic step(input logic r, input logic k, input logic [3:0] exp, input string name);
      rst   = r;
      key_n = k;
      @(posedge clk);
      #1;
      edge_n++;
      n_cmp++;
      if ({level, press, rel, rep} !== exp) begin
         n_bad++;
         $display("FAIL %s edge %0d: level/press/release/repeat got %b required %b",
                  name, edge_n, {level, press, rel, rep}, exp);
      end
   endtask

   initial begin
      logic       l, p, r, q;
      logic [3:0] ex;

      rst   = 1'b1;
      key_n = 1'b1;

      // Scenario A table: press sampled at edge 10, held, released sampled at edge 72.
      for (int e = 1; e <= NVEC_A; e++) begin
         l = (e >= 16 && e < 78);
         p = (e == 16);
         r = (e == 78);
         q = (e >= 36 && e < 78 && ((e - 36) % REP) == 0);
         vecs[e-1].rst   = (e <= 3);
         vecs[e-1].key_n = !(e >= 10 && e < 72);
         vecs[e-1].exp   = {l, p, r, q};
      end

      // Reset held with key pressed, then press accepted 6 edges after the first free edge.
      edge_n = 0;
      for (int e = 1; e <= 14; e++) begin
         ex = {(e >= 10), (e == 10), 1'b0, 1'b0};
         step(e <= 3, 1'b0, ex, "reset_hold");
      end

      edge_n = 0;
      for (int i = 0; i < NVEC_A; i++)
         step(vecs[i].rst, vecs[i].key_n, vecs[i].exp, "vecA");

      // Bounce: low 3, high 1, low 3, high; nothing may be accepted.
      edge_n = 0;
      for (int e = 1; e <= 30; e++) begin
         k_bounce: begin
            logic kb;
            kb = !((e >= 10 && e <= 12) || (e >= 14 && e <= 16));
            step(e <= 3, kb, 4'b0000, "bounce");
         end
      end

      // Release acceptance lands on the hold terminal count at edge 36.
      edge_n = 0;
      for (int e = 1; e <= 50; e++) begin
         ex = {(e >= 16 && e < 36), (e == 16), (e == 36), 1'b0};
         step(e <= 3, !(e >= 10 && e < 30), ex, "collision");
         if (e == 36) begin
            n_cmp++;
            if (dut.state_q !== ST_IDLE) begin
               n_bad++;
               $display("FAIL collision_state: state got %0d required %0d", dut.state_q, ST_IDLE);
            end
         end
      end

      // Reset at edge 40 while in REPEAT; key stays low so a fresh press follows.
      edge_n = 0;
      for (int e = 1; e <= 52; e++) begin
         ex = {((e >= 16 && e < 40) || e >= 47), (e == 16 || e == 47), 1'b0, (e == 36)};
         step(e <= 3 || e == 40, !(e >= 10), ex, "midreset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
